// File: rtl/i2c_reg_arbiter_if.sv
// i2c_reg_arbiter_if -- bus bundle between the register arbiter and its users.
//   I2C side  : i2c_we, i2c_reg_addr, i2c_datao, i2c_busy -> arbiter; i2c_datai <- arbiter
//   Host side : host_req, host_we, host_addr, host_wdata -> arbiter; host_ack, host_rdata <- arbiter
//   Update    : upd_valid, upd_addr, upd_src <- arbiter
//   Status    : clr_err -> arbiter; timeout_err, stall_count <- arbiter
// The arbiter connects through the slave modport, the driving side through master.
interface i2c_reg_arbiter_if;
  logic        i2c_we;
  logic [7:0]  i2c_reg_addr;
  logic [15:0] i2c_datao;
  logic        i2c_busy;
  logic [15:0] i2c_datai;

  logic        host_req;
  logic        host_we;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;

  logic        upd_valid;
  logic [7:0]  upd_addr;
  logic        upd_src;

  logic        clr_err;
  logic        timeout_err;
  logic [7:0]  stall_count;

  modport master (
    output i2c_we, i2c_reg_addr, i2c_datao, i2c_busy,
    input  i2c_datai,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata,
    input  upd_valid, upd_addr, upd_src,
    output clr_err,
    input  timeout_err, stall_count
  );

  modport slave (
    input  i2c_we, i2c_reg_addr, i2c_datao, i2c_busy,
    output i2c_datai,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata,
    output upd_valid, upd_addr, upd_src,
    input  clr_err,
    output timeout_err, stall_count
  );
endinterface

// File: rtl/i2c_reg_arbiter.sv
// i2c_reg_arbiter -- shared 16-bit register bank behind an I2C slave register
// port and a local host req/ack port. The I2C port is never stalled; host
// accesses wait while an I2C write strobe is present and, with HOST_LOCK=1,
// while an I2C transaction is in progress, unless forced through after TIMEOUT
// blocked cycles. Each committed write is reported on the update strobe.
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      i2c_reg_arbiter_if.slave (I2C port, host port, update strobe, status)
module i2c_reg_arbiter #(
  parameter int unsigned NUM_REGS  = 64,
  parameter int unsigned HOST_LOCK = 1,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  i2c_reg_arbiter_if.slave  bus
);

  localparam int unsigned AW           = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0]  NUM_REGS_W   = 9'(NUM_REGS);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic        LOCK_EN      = (HOST_LOCK != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t state;
  state_t state_next;

  logic [15:0]   regs [NUM_REGS];
  logic [15:0]   wait_cnt;
  logic          forced;

  logic          i2c_in_range;
  logic          host_in_range;
  logic [AW-1:0] i2c_idx;
  logic [AW-1:0] host_idx;
  logic          i2c_commit;
  logic          host_commit;
  logic          blocked;
  logic          busy_block;

  logic          host_go;
  logic          enter_wait;
  logic          wait_tick;
  logic          force_now;
  logic          clr_forced;

  // ---------------------------------------------------------------------------
  // Address decode and blocking conditions
  // ---------------------------------------------------------------------------
  always_comb begin
    i2c_in_range  = ({1'b0, bus.i2c_reg_addr} < NUM_REGS_W);
    host_in_range = ({1'b0, bus.host_addr} < NUM_REGS_W);
    i2c_idx       = bus.i2c_reg_addr[AW-1:0];
    host_idx      = bus.host_addr[AW-1:0];
  end

  always_comb begin
    blocked    = bus.i2c_we | (LOCK_EN & bus.i2c_busy & ~forced);
    // Blocked purely by the transaction lock: only these cycles count
    // towards the forced-through timeout.
    busy_block = ~bus.i2c_we & LOCK_EN & bus.i2c_busy & ~forced;
  end

  // ---------------------------------------------------------------------------
  // Host FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Host FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (bus.host_req) begin
          state_next = blocked ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        if (!blocked) begin
          state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Host FSM: outputs / control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    host_go      = 1'b0;
    enter_wait   = 1'b0;
    wait_tick    = 1'b0;
    clr_forced   = 1'b0;
    bus.host_ack = 1'b0;
    case (state)
      ST_IDLE: begin
        host_go    = bus.host_req & ~blocked;
        enter_wait = bus.host_req & blocked;
      end
      ST_WAIT: begin
        // The access completes even if host_req was dropped while waiting.
        host_go   = ~blocked;
        wait_tick = busy_block;
      end
      ST_ACK: begin
        bus.host_ack = 1'b1;
        clr_forced   = 1'b1;
      end
      default: begin
        host_go = 1'b0;
      end
    endcase
  end

  always_comb begin
    force_now   = wait_tick & (wait_cnt == TIMEOUT_LAST);
    i2c_commit  = bus.i2c_we & i2c_in_range;
    // host_go already excludes i2c_we, so the two commits are exclusive.
    host_commit = host_go & bus.host_we & host_in_range;
  end

  // ---------------------------------------------------------------------------
  // Register storage and zero-latency I2C read path
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (i2c_commit) begin
      regs[i2c_idx] <= bus.i2c_datao;
    end else if (host_commit) begin
      regs[host_idx] <= bus.host_wdata;
    end
  end

  always_comb begin
    bus.i2c_datai = '0;
    if (i2c_in_range) begin
      bus.i2c_datai = regs[i2c_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Wait counter and forced-through flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      forced   <= 1'b0;
    end else begin
      if (enter_wait) begin
        wait_cnt <= '0;
      end else if (wait_tick) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (clr_forced) begin
        forced <= 1'b0;
      end else if (force_now) begin
        forced <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status: sticky timeout flag (set wins over clear), saturating stall count
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.timeout_err <= 1'b0;
      bus.stall_count <= '0;
    end else begin
      if (force_now) begin
        bus.timeout_err <= 1'b1;
      end else if (bus.clr_err) begin
        bus.timeout_err <= 1'b0;
      end
      if (enter_wait && (bus.stall_count != '1)) begin
        bus.stall_count <= bus.stall_count + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Host read data, held until the next read
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.host_rdata <= '0;
    end else if (host_go && !bus.host_we) begin
      bus.host_rdata <= host_in_range ? regs[host_idx] : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Update strobe, one cycle after the commit edge
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.upd_valid <= 1'b0;
      bus.upd_addr  <= '0;
      bus.upd_src   <= 1'b0;
    end else begin
      bus.upd_valid <= i2c_commit | host_commit;
      if (i2c_commit) begin
        bus.upd_addr <= bus.i2c_reg_addr;
        bus.upd_src  <= 1'b0;
      end else if (host_commit) begin
        bus.upd_addr <= bus.host_addr;
        bus.upd_src  <= 1'b1;
      end
    end
  end

  a_single_commit: assert property (
    @(posedge clk) disable iff (!reset_n) !(i2c_commit && host_commit)
  );

endmodule
